// File: rtl/estado_mascota.sv
// Pet-state arbiter: picks which need is served, drives the matching Activo_* enable
// and produces the face code, the 1 Hz critical blink and the sticky death flag.
module estado_mascota #(
    parameter int TICK_CICLOS = 50_000_000,
    parameter int MUERTE_SEG  = 10,
    parameter int UMBRAL      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:1] Nivel_Animo,
    input  logic [0:1] Nivel_Energia,
    input  logic [0:1] Nivel_Descanso,
    input  logic [0:1] Nivel_Medicina,
    input  logic       senal_5segAnimo,
    input  logic       senal_5segEnergia,
    input  logic       senal_5segDescanso,
    input  logic       senal_5segMedicina,
    input  logic       Senal_Test,
    output logic       Activo_Carisia,
    output logic       Activo_Comida,
    output logic       Activo_Descanso,
    output logic       Activo_Medicina,
    output logic [2:0] Estado,
    output logic       Alerta,
    output logic       Muerto
);
    localparam int DW = (TICK_CICLOS > 1) ? $clog2(TICK_CICLOS) : 1;
    localparam int CW = (MUERTE_SEG > 0) ? $clog2(MUERTE_SEG + 1) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_CICLOS - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MUERTE_SEG);

    typedef enum logic [2:0] {
        S_FELIZ,
        S_ATENDER,
        S_CRITICO,
        S_MUERTO,
        S_TEST
    } state_t;

    // Need vectors are ordered by priority: bit 3 Medicina down to bit 0 Animo.
    logic [1:0] nivel [4];
    logic [3:0] senal;
    logic [3:0] need;
    logic [3:0] zero;

    assign nivel[3] = Nivel_Medicina;
    assign nivel[2] = Nivel_Energia;
    assign nivel[1] = Nivel_Descanso;
    assign nivel[0] = Nivel_Animo;
    assign senal    = {senal_5segMedicina, senal_5segEnergia, senal_5segDescanso, senal_5segAnimo};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_need
            assign need[gi] = (32'(nivel[gi]) <= UMBRAL);
            assign zero[gi] = (nivel[gi] == 2'd0);
        end
    endgenerate

    function automatic logic [3:0] top1(input logic [3:0] v);
        if (v[3]) return 4'b1000;
        if (v[2]) return 4'b0100;
        if (v[1]) return 4'b0010;
        if (v[0]) return 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic [2:0] face_of(input logic [3:0] oh);
        if (oh[3]) return 3'd2;
        if (oh[2]) return 3'd1;
        if (oh[1]) return 3'd3;
        if (oh[0]) return 3'd4;
        return 3'd0;
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      estado_q, estado_d;
    logic [3:0]      activo_q, activo_d;
    logic            alerta_q, alerta_d;
    logic            muerto_q, muerto_d;
    logic            tick;
    logic [3:0]      need_top;
    logic [3:0]      zero_top;

    assign tick     = (div_q == DIV_MAX);
    assign need_top = top1(need);
    assign zero_top = top1(zero);

    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + 1'b1;
        cnt_d    = '0;
        estado_d = 3'd0;
        activo_d = 4'b0000;
        alerta_d = 1'b0;
        muerto_d = 1'b0;

        if (state_q == S_MUERTO)
            state_d = S_MUERTO;
        else if (Senal_Test)
            state_d = S_TEST;
        else if (state_q == S_TEST)
            state_d = S_FELIZ;
        else if (state_q == S_CRITICO && cnt_q == CNT_MAX)
            state_d = S_MUERTO;
        else if (|zero)
            state_d = S_CRITICO;
        else if (|need)
            state_d = S_ATENDER;
        else
            state_d = S_FELIZ;

        // Care on the served need beats a coincident tick.
        if (state_q == S_CRITICO && state_d == S_CRITICO) begin
            if (|(senal & zero_top))
                cnt_d = '0;
            else if (tick && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            else
                cnt_d = cnt_q;
        end

        case (state_d)
            S_ATENDER: begin
                estado_d = face_of(need_top);
                activo_d = need_top;
            end
            S_CRITICO: begin
                estado_d = 3'd5;
                activo_d = zero_top;
                alerta_d = (state_q == S_CRITICO && tick) ? ~alerta_q : alerta_q;
            end
            S_MUERTO: begin
                estado_d = 3'd6;
                muerto_d = 1'b1;
            end
            S_TEST: begin
                estado_d = 3'd7;
                activo_d = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FELIZ;
            div_q    <= '0;
            cnt_q    <= '0;
            estado_q <= 3'd0;
            activo_q <= 4'b0000;
            alerta_q <= 1'b0;
            muerto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            estado_q <= estado_d;
            activo_q <= activo_d;
            alerta_q <= alerta_d;
            muerto_q <= muerto_d;
        end
    end

    assign Activo_Medicina = activo_q[3];
    assign Activo_Comida   = activo_q[2];
    assign Activo_Descanso = activo_q[1];
    assign Activo_Carisia  = activo_q[0];
    assign Estado          = estado_q;
    assign Alerta          = alerta_q;
    assign Muerto          = muerto_q;

endmodule

// File: tb/tb_estado_mascota.sv
// Bench for estado_mascota: directed test-plan steps followed by random levels,
// all checked against a behavioural pet model.
module tb_estado_mascota;
    localparam int TICK   = 4;
    localparam int MUERTE = 3;
    localparam int UMB    = 1;

    localparam int HAPPY = 0;
    localparam int SERVE = 1;
    localparam int CRIT  = 2;
    localparam int DEAD  = 3;
    localparam int TEST  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:1] Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina;
    logic       senal_5segAnimo, senal_5segEnergia, senal_5segDescanso, senal_5segMedicina;
    logic       Senal_Test;
    logic       Activo_Carisia, Activo_Comida, Activo_Descanso, Activo_Medicina;
    logic [2:0] Estado;
    logic       Alerta, Muerto;

    int total = 0;
    int bad   = 0;

    // Needs in priority order: 0 Medicina, 1 Energia, 2 Descanso, 3 Animo.
    int         lv[4];
    logic [3:0] pulse;
    int         code_of[4] = '{2, 1, 3, 4};

    int         m_mode, m_count, m_cyc;
    logic       m_alert;
    logic [2:0] exp_estado;
    logic [3:0] exp_act;
    logic       exp_alerta, exp_muerto;

    always #5 clk = ~clk;

    estado_mascota #(
        .TICK_CICLOS(TICK),
        .MUERTE_SEG (MUERTE),
        .UMBRAL     (UMB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .Nivel_Animo       (Nivel_Animo),
        .Nivel_Energia     (Nivel_Energia),
        .Nivel_Descanso    (Nivel_Descanso),
        .Nivel_Medicina    (Nivel_Medicina),
        .senal_5segAnimo   (senal_5segAnimo),
        .senal_5segEnergia (senal_5segEnergia),
        .senal_5segDescanso(senal_5segDescanso),
        .senal_5segMedicina(senal_5segMedicina),
        .Senal_Test        (Senal_Test),
        .Activo_Carisia    (Activo_Carisia),
        .Activo_Comida     (Activo_Comida),
        .Activo_Descanso   (Activo_Descanso),
        .Activo_Medicina   (Activo_Medicina),
        .Estado            (Estado),
        .Alerta            (Alerta),
        .Muerto            (Muerto)
    );

    function automatic logic [3:0] act_now();
        return {Activo_Medicina, Activo_Comida, Activo_Descanso, Activo_Carisia};
    endfunction

    task automatic drive();
        Nivel_Medicina     = 2'(lv[0]);
        Nivel_Energia      = 2'(lv[1]);
        Nivel_Descanso     = 2'(lv[2]);
        Nivel_Animo        = 2'(lv[3]);
        senal_5segMedicina = pulse[0];
        senal_5segEnergia  = pulse[1];
        senal_5segDescanso = pulse[2];
        senal_5segAnimo    = pulse[3];
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 4; i++) lv[i] = v;
    endtask

    task automatic model_reset();
        m_mode     = HAPPY;
        m_count    = 0;
        m_cyc      = 0;
        m_alert    = 1'b0;
        exp_estado = 3'd0;
        exp_act    = 4'b0000;
        exp_alerta = 1'b0;
        exp_muerto = 1'b0;
    endtask

    // One rising edge of the pet's life, computed from the behavioural rules.
    task automatic model_edge();
        bit tick;
        int prev, nxt, zi, ni;
        tick = ((m_cyc % TICK) == TICK - 1);
        m_cyc++;
        zi = -1;
        ni = -1;
        for (int i = 3; i >= 0; i--) begin
            if (lv[i] == 0) zi = i;
            if (lv[i] <= UMB) ni = i;
        end
        prev = m_mode;
        if (prev == DEAD)                            nxt = DEAD;
        else if (Senal_Test)                         nxt = TEST;
        else if (prev == TEST)                       nxt = HAPPY;
        else if (prev == CRIT && m_count >= MUERTE)  nxt = DEAD;
        else if (zi >= 0)                            nxt = CRIT;
        else if (ni >= 0)                            nxt = SERVE;
        else                                         nxt = HAPPY;

        if (prev == CRIT && nxt == CRIT) begin
            if (pulse[zi])  m_count = 0;
            else if (tick)  m_count = (m_count + 1 > MUERTE) ? MUERTE : m_count + 1;
        end else if (nxt != DEAD) begin
            m_count = 0;
        end
        if (nxt == CRIT) m_alert = (prev == CRIT && tick) ? ~m_alert : m_alert;
        else             m_alert = 1'b0;
        m_mode = nxt;

        exp_act    = 4'b0000;
        exp_muerto = 1'b0;
        exp_estado = 3'd0;
        case (nxt)
            SERVE: begin exp_estado = 3'(code_of[ni]); exp_act[3-ni] = 1'b1; end
            CRIT:  begin exp_estado = 3'd5;            exp_act[3-zi] = 1'b1; end
            DEAD:  begin exp_estado = 3'd6;            exp_muerto    = 1'b1; end
            TEST:  begin exp_estado = 3'd7;            exp_act       = 4'b1111; end
            default: ;
        endcase
        exp_alerta = m_alert;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] a;
        a = act_now();
        total++;
        assert (Estado === exp_estado) else begin
            bad++; $error("FAIL %s Estado got=%0d exp=%0d", tag, Estado, exp_estado);
        end
        total++;
        assert (a === exp_act) else begin
            bad++; $error("FAIL %s Activo got=%b exp=%b", tag, a, exp_act);
        end
        total++;
        assert (Alerta === exp_alerta) else begin
            bad++; $error("FAIL %s Alerta got=%b exp=%b", tag, Alerta, exp_alerta);
        end
        total++;
        assert (Muerto === exp_muerto) else begin
            bad++; $error("FAIL %s Muerto got=%b exp=%b", tag, Muerto, exp_muerto);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++; $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag);
        drive();
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset is pulled mid-cycle so outputs must clear without a clock edge.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, "_hold"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int toggles, n;
        logic prev_al;

        reset      = 1'b0;
        Senal_Test = 1'b0;
        pulse      = 4'b0000;
        set_all(3);
        drive();
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Preemption
        step("all_full");
        chk("feliz", {Estado, act_now()}, {3'd0, 4'b0000});
        lv[3] = 1;
        step("animo_low");
        chk("triste", {Estado, act_now()}, {3'd4, 4'b0001});
        lv[0] = 1;
        step("med_low");
        chk("enfermo", {Estado, act_now()}, {3'd2, 4'b1000});

        // Served need recovers
        set_all(3);
        lv[1] = 1;
        step("energia_low");
        chk("hambre", {Estado, act_now()}, {3'd1, 4'b0100});
        lv[1] = 2;
        step("energia_ok");
        chk("back_feliz", {Estado, act_now()}, {3'd0, 4'b0000});

        // Critical on Descanso, care pulse after two ticks, then death
        lv[2] = 0;
        for (int i = 0; i < 40 && m_count != 2; i++) step("crit_wait");
        chk("critico", {Estado, act_now()}, {3'd5, 4'b0010});
        pulse[2] = 1'b1;
        step("care_pulse");
        pulse[2] = 1'b0;
        toggles = 0;
        prev_al = Alerta;
        for (int i = 0; i < 60 && Muerto !== 1'b1; i++) begin
            step("crit_hold");
            if (Estado == 3'd5 && Alerta !== prev_al) toggles++;
            prev_al = Alerta;
        end
        chk("ticks_after_care", toggles, 3);
        chk("death", {Estado, act_now(), Muerto}, {3'd6, 4'b0000, 1'b1});

        set_all(3);
        Senal_Test = 1'b1;
        repeat (6) step("dead_hold");
        chk("dead_sticky", {Estado, act_now(), Muerto}, {3'd6, 4'b0000, 1'b1});
        Senal_Test = 1'b0;
        apply_reset("reset_after_death");

        // Test mode from CRITICO
        lv[2] = 0;
        repeat (3) step("crit_again");
        Senal_Test = 1'b1;
        step("test_on");
        chk("test_face", {Estado, act_now()}, {3'd7, 4'b1111});
        set_all(3);
        Senal_Test = 1'b0;
        step("test_off");
        chk("test_exit", {Estado, act_now()}, {3'd0, 4'b0000});

        // Reset mid-ATENDER, then first tick timing
        lv[3] = 1;
        step("attend_before_reset");
        apply_reset("reset_mid_attend");
        chk("async_clear", {Estado, act_now(), Alerta, Muerto}, 0);
        set_all(3);
        lv[0] = 0;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step("first_tick_wait");
            if (Alerta === 1'b1) n = i;
        end
        chk("first_tick", n, TICK);

        // Random phase
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                int r;
                r = int'($urandom_range(0, 15));
                lv[i] = (r == 0) ? 0 : (r < 4) ? 1 : (r < 10) ? 2 : 3;
                pulse[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 19) == 0) Senal_Test = ~Senal_Test;
            step("random");
            if (exp_muerto && $urandom_range(0, 3) == 0) apply_reset("random_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
